// File: rtl/ps2_scan_decoder_if.sv
// Byte-in / event-out bundle between the PS/2 receiver side and the
// scan-code decoder. The receiver/consumer side is the master; the
// decoder is the slave.
interface ps2_scan_decoder_if;
    logic       CODE_VALID;
    logic [7:0] CODE;
    logic       CODE_ERR;
    logic       EVT_VALID;
    logic [9:0] EVT_DATA;
    logic       EVT_READ;
    logic [4:0] KEY_HELD;
    logic       KB_OK;
    logic       KB_ERR;
    logic       OVERFLOW;

    modport master (
        output CODE_VALID, CODE, CODE_ERR, EVT_READ,
        input  EVT_VALID, EVT_DATA, KEY_HELD, KB_OK, KB_ERR, OVERFLOW
    );

    modport slave (
        input  CODE_VALID, CODE, CODE_ERR, EVT_READ,
        output EVT_VALID, EVT_DATA, KEY_HELD, KB_OK, KB_ERR, OVERFLOW
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0 prefixes into key events
// {EXT, REL, KEYCODE}, queues them in a small FIFO, tracks held state of
// the arrow keys and '1', and latches the keyboard self-test result.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 2500000
) (
    input logic                CLK,
    input logic                RESET,
    ps2_scan_decoder_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    // Held-key table, bit order {one, right, left, down, up}
    localparam logic [7:0] KEY_CODES [5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h16};
    localparam logic [4:0] KEY_EXT       = 5'b01111;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t         state_reg, state_next;
    logic [TW-1:0]  tmo_reg;
    logic           evt_gen, evt_ext, evt_rel;
    logic           set_ok, set_err;
    logic [9:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           do_push, do_pop, fifo_full;
    logic [4:0]     key_hit, held_reg, held_next;
    logic           kb_ok_reg, kb_err_reg, overflow_reg;

    // Prefix FSM next state and event decode; only valid bytes advance it
    always_comb begin
        state_next = state_reg;
        evt_gen    = 1'b0;
        evt_ext    = 1'b0;
        evt_rel    = 1'b0;
        set_ok     = 1'b0;
        set_err    = 1'b0;
        if (bus.CODE_VALID) begin
            if (bus.CODE_ERR) begin
                state_next = IDLE;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        case (bus.CODE)
                            8'hE0: state_next = EXT;
                            8'hF0: state_next = BRK;
                            8'hAA: set_ok = 1'b1;
                            8'hFC: set_err = 1'b1;
                            8'hE1, 8'h00: ;
                            default: evt_gen = 1'b1;
                        endcase
                    end
                    EXT: begin
                        case (bus.CODE)
                            8'hF0: state_next = EXT_BRK;
                            8'hE0: state_next = EXT;
                            default: begin
                                evt_gen    = 1'b1;
                                evt_ext    = 1'b1;
                                state_next = IDLE;
                            end
                        endcase
                    end
                    BRK: begin
                        state_next = IDLE;
                        if (bus.CODE != 8'hE0 && bus.CODE != 8'hF0) begin
                            evt_gen = 1'b1;
                            evt_rel = 1'b1;
                        end
                    end
                    EXT_BRK: begin
                        state_next = IDLE;
                        if (bus.CODE != 8'hE0 && bus.CODE != 8'hF0) begin
                            evt_gen = 1'b1;
                            evt_ext = 1'b1;
                            evt_rel = 1'b1;
                        end
                    end
                endcase
            end
        end else if (state_reg != IDLE && tmo_reg == TMO_LAST) begin
            // A stalled prefix is abandoned; a byte in this cycle would have won
            state_next = IDLE;
        end
    end

    // FSM state register and prefix timeout counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (bus.CODE_VALID || state_reg == IDLE)
                tmo_reg <= '0;
            else
                tmo_reg <= tmo_reg + 1'b1;
        end
    end

    // Per-key hit detection; extended-ness must match so keypad codes are ignored
    for (genvar gi = 0; gi < 5; gi++) begin : g_keys
        assign key_hit[gi]   = evt_gen && (bus.CODE == KEY_CODES[gi]) && (evt_ext == KEY_EXT[gi]);
        assign held_next[gi] = key_hit[gi] ? ~evt_rel : held_reg[gi];
    end

    // Held-key state and sticky status flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            held_reg     <= '0;
            kb_ok_reg    <= 1'b0;
            kb_err_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            held_reg <= held_next;
            if (set_ok) begin
                kb_ok_reg  <= 1'b1;
                kb_err_reg <= 1'b0;
            end else if (set_err) begin
                kb_err_reg <= 1'b1;
                kb_ok_reg  <= 1'b0;
            end
            if (evt_gen && fifo_full && !do_pop)
                overflow_reg <= 1'b1;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign fifo_full = (count_reg == FIFO_FULL);
    assign do_pop    = bus.EVT_READ && (count_reg != '0);
    assign do_push   = evt_gen && (!fifo_full || do_pop);

    // Event storage; no reset needed since the head is masked while empty
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr_reg] <= {evt_ext, evt_rel, bus.CODE};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bus.EVT_VALID = (count_reg != '0);
    assign bus.EVT_DATA  = (count_reg != '0) ? mem[rd_ptr_reg] : 10'h000;
    assign bus.KEY_HELD  = held_reg;
    assign bus.KB_OK     = kb_ok_reg;
    assign bus.KB_ERR    = kb_err_reg;
    assign bus.OVERFLOW  = overflow_reg;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: table of byte sequences with a
// scoreboard queue of expected events, plus hand-written corner cases.
module tb_ps2_scan_decoder;
    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [9:0] exp_q[$];

    ps2_scan_decoder_if bus();

    ps2_scan_decoder #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(100)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         len;
        logic       err_last;
        logic       has_evt;
        logic [9:0] evt;
        logic [4:0] held;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge CLK);
        bus.CODE_VALID = 1'b1;
        bus.CODE       = b;
        bus.CODE_ERR   = err;
        @(negedge CLK);
        bus.CODE_VALID = 1'b0;
        bus.CODE_ERR   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Compare the head against the scoreboard, then pop it
    task automatic pop_expect(input string name);
        logic [9:0] e;
        chk({name, "_valid"}, 32'(bus.EVT_VALID), 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: scoreboard empty, got %0h expected none", name, bus.EVT_DATA);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_data"}, 32'(bus.EVT_DATA), 32'(e));
        end
        bus.EVT_READ = 1'b1;
        @(negedge CLK);
        bus.EVT_READ = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 16) begin
            pop_expect(name);
            guard++;
        end
        chk({name, "_empty"}, 32'(bus.EVT_VALID), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        idle(2);
        RESET = 1'b0;
        exp_q.delete();
    endtask

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, input int len,
                                input logic err, has, input logic [9:0] evt,
                                input logic [4:0] held);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.len = len;
        v.err_last = err; v.has_evt = has; v.evt = evt; v.held = held;
        return v;
    endfunction

    initial begin
        logic [7:0] b;
        logic [9:0] head;

        vecs[0]  = mk(8'h1C, 8'h00, 8'h00, 1, 0, 1, 10'h01C, 5'b00000);
        vecs[1]  = mk(8'hF0, 8'h1C, 8'h00, 2, 0, 1, 10'h11C, 5'b00000);
        vecs[2]  = mk(8'hE0, 8'h75, 8'h00, 2, 0, 1, 10'h275, 5'b00001);
        vecs[3]  = mk(8'hE0, 8'hF0, 8'h75, 3, 0, 1, 10'h375, 5'b00000);
        vecs[4]  = mk(8'h75, 8'h00, 8'h00, 1, 0, 1, 10'h075, 5'b00000);
        vecs[5]  = mk(8'h16, 8'h00, 8'h00, 1, 0, 1, 10'h016, 5'b10000);
        vecs[6]  = mk(8'hE0, 8'h72, 8'h00, 2, 0, 1, 10'h272, 5'b10010);
        vecs[7]  = mk(8'hE0, 8'h6B, 8'h00, 2, 0, 1, 10'h26B, 5'b10110);
        vecs[8]  = mk(8'hE0, 8'h74, 8'h00, 2, 0, 1, 10'h274, 5'b11110);
        vecs[9]  = mk(8'hE0, 8'hE0, 8'h74, 3, 0, 1, 10'h274, 5'b11110);
        vecs[10] = mk(8'hF0, 8'h16, 8'h00, 2, 0, 1, 10'h116, 5'b01110);
        vecs[11] = mk(8'hE0, 8'hF0, 8'h72, 3, 0, 1, 10'h372, 5'b01100);
        vecs[12] = mk(8'hF0, 8'hE0, 8'h00, 2, 0, 0, 10'h000, 5'b01100);
        vecs[13] = mk(8'hE1, 8'h00, 8'h00, 1, 0, 0, 10'h000, 5'b01100);
        vecs[14] = mk(8'h00, 8'h00, 8'h00, 1, 0, 0, 10'h000, 5'b01100);
        vecs[15] = mk(8'hE0, 8'hF0, 8'hF0, 3, 0, 0, 10'h000, 5'b01100);
        vecs[16] = mk(8'hE0, 8'h74, 8'h00, 2, 1, 0, 10'h000, 5'b01100);
        vecs[17] = mk(8'h74, 8'h00, 8'h00, 1, 0, 1, 10'h074, 5'b01100);
        vecs[18] = mk(8'h6B, 8'h00, 8'h00, 1, 0, 1, 10'h06B, 5'b01100);
        vecs[19] = mk(8'hE0, 8'hF0, 8'h6B, 3, 0, 1, 10'h36B, 5'b01000);
        vecs[20] = mk(8'hE0, 8'hF0, 8'h74, 3, 0, 1, 10'h374, 5'b00000);

        RESET = 1'b1;
        bus.CODE_VALID = 1'b0;
        bus.CODE = 8'h00;
        bus.CODE_ERR = 1'b0;
        bus.EVT_READ = 1'b0;
        idle(3);
        chk("rst_evt_valid", 32'(bus.EVT_VALID), 32'd0);
        chk("rst_evt_data",  32'(bus.EVT_DATA),  32'd0);
        chk("rst_key_held",  32'(bus.KEY_HELD),  32'd0);
        chk("rst_kb_ok",     32'(bus.KB_OK),     32'd0);
        chk("rst_kb_err",    32'(bus.KB_ERR),    32'd0);
        chk("rst_overflow",  32'(bus.OVERFLOW),  32'd0);
        RESET = 1'b0;
        idle(1);

        // First event is visible one cycle after its CODE_VALID; second waits behind it
        @(negedge CLK);
        bus.CODE_VALID = 1'b1; bus.CODE = 8'h1C;
        chk("lat_before", 32'(bus.EVT_VALID), 32'd0);
        @(negedge CLK);
        bus.CODE_VALID = 1'b0;
        chk("lat_after", 32'(bus.EVT_VALID), 32'd1);
        exp_q.push_back(10'h01C);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        exp_q.push_back(10'h11C);
        drain("lat");

        // Table-driven sequences
        for (int i = 0; i < 21; i++) begin
            for (int j = 0; j < vecs[i].len; j++) begin
                b = (j == 0) ? vecs[i].b0 : (j == 1) ? vecs[i].b1 : vecs[i].b2;
                send_byte(b, vecs[i].err_last && (j == vecs[i].len - 1));
            end
            if (vecs[i].has_evt) exp_q.push_back(vecs[i].evt);
            chk($sformatf("vec%0d_held", i), 32'(bus.KEY_HELD), 32'(vecs[i].held));
            drain($sformatf("vec%0d", i));
        end

        // Self-test result bytes
        send_byte(8'hAA, 1'b0);
        chk("aa_ok",  32'(bus.KB_OK),     32'd1);
        chk("aa_err", 32'(bus.KB_ERR),    32'd0);
        chk("aa_evt", 32'(bus.EVT_VALID), 32'd0);
        send_byte(8'hFC, 1'b0);
        chk("fc_ok",  32'(bus.KB_OK),     32'd0);
        chk("fc_err", 32'(bus.KB_ERR),    32'd1);
        chk("fc_evt", 32'(bus.EVT_VALID), 32'd0);

        // Prefix survives a wait well below the timeout
        send_byte(8'hE0, 1'b0);
        idle(50);
        send_byte(8'h74, 1'b0);
        exp_q.push_back(10'h274);
        chk("tmo_short_held", 32'(bus.KEY_HELD), 32'd8);
        drain("tmo_short");
        // Prefix is dropped after the timeout
        send_byte(8'hE0, 1'b0);
        idle(105);
        send_byte(8'h74, 1'b0);
        exp_q.push_back(10'h074);
        chk("tmo_long_held", 32'(bus.KEY_HELD), 32'd8);
        drain("tmo_long");
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        idle(105);
        send_byte(8'h74, 1'b0);
        exp_q.push_back(10'h074);
        chk("tmo_brk_held", 32'(bus.KEY_HELD), 32'd8);
        drain("tmo_brk");

        // FIFO fill, push+pop while full, then overflow
        do_reset();
        send_byte(8'h15, 1'b0); exp_q.push_back(10'h015);
        send_byte(8'h1D, 1'b0); exp_q.push_back(10'h01D);
        send_byte(8'h24, 1'b0); exp_q.push_back(10'h024);
        send_byte(8'h2D, 1'b0); exp_q.push_back(10'h02D);
        chk("full_no_ovf", 32'(bus.OVERFLOW), 32'd0);
        @(negedge CLK);
        bus.CODE_VALID = 1'b1; bus.CODE = 8'h35; bus.EVT_READ = 1'b1;
        head = exp_q.pop_front();
        chk("pp_head", 32'(bus.EVT_DATA), 32'(head));
        exp_q.push_back(10'h035);
        @(negedge CLK);
        bus.CODE_VALID = 1'b0; bus.EVT_READ = 1'b0;
        chk("pp_no_ovf", 32'(bus.OVERFLOW), 32'd0);
        send_byte(8'h3C, 1'b0);
        chk("ovf_set", 32'(bus.OVERFLOW), 32'd1);
        drain("ovf");

        // Reset in the middle of a prefix, with a byte arriving during reset
        send_byte(8'hAA, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        @(negedge CLK);
        RESET = 1'b1; bus.CODE_VALID = 1'b1; bus.CODE = 8'h6B;
        @(negedge CLK);
        bus.CODE_VALID = 1'b0;
        chk("mid_rst_valid", 32'(bus.EVT_VALID), 32'd0);
        chk("mid_rst_held",  32'(bus.KEY_HELD),  32'd0);
        chk("mid_rst_ok",    32'(bus.KB_OK),     32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        exp_q.delete();
        chk("post_rst_valid", 32'(bus.EVT_VALID), 32'd0);
        send_byte(8'h6B, 1'b0);
        exp_q.push_back(10'h06B);
        chk("post_rst_held", 32'(bus.KEY_HELD), 32'd0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
